// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate sequencer and the occupancy block.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_ID = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    CLOSE   = 3'd4,
    REJECT  = 3'd5
  } gate_state_t;

  localparam int CYCLES_PER_MIN = 60;
  localparam int UNI_CAP        = 200;
  localparam int VISITOR_CAP    = 500;

  function automatic int minutes_to_cycles(input int minutes);
    return minutes * CYCLES_PER_MIN;
  endfunction

endpackage

// File: rtl/gate_debounce.sv
// Level debounce: hit is high on the DEBOUNCE-th consecutive enabled cycle with level high.
module gate_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic level,
  output logic hit
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  // Run-length counter; any low or disabled cycle restarts it, saturates at DEBOUNCE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || !level) begin
      cnt <= '0;
    end else if (cnt != CW'(DEBOUNCE)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit = en && level && (cnt == CW'(DEBOUNCE - 1));

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate-side sequencer: debounce arrival, wait for permit, check vacancy,
// drive the barrier and emit one event pulse per vehicle that clears it.
//
// state   | meaning
// IDLE    | barrier closed, waiting for a stable vehicle presence
// WAIT_ID | vehicle present, waiting for a permit read
// CHECK   | one cycle: vacancy decision (skipped on exit gates)
// OPEN    | barrier up, waiting for the vehicle to cross the pass loop
// CLOSE   | barrier down, hold-off before accepting a new vehicle
// REJECT  | reject lamp lit until hold time elapsed and vehicle gone
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter bit EXIT_GATE    = 1'b0,
  parameter int DEBOUNCE     = 4,
  parameter int ID_TIMEOUT   = minutes_to_cycles(20),
  parameter int PASS_TIMEOUT = 600,
  parameter int CLOSE_HOLD   = 8,
  parameter int REJECT_HOLD  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_detect,
  input  logic       pass_sensor,
  input  logic       card_valid,
  input  logic       is_uni_card,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       barrier_open,
  output logic       reject_lamp,
  output logic       car_event,
  output logic       is_uni_event,
  output logic       abort_pulse,
  output logic [2:0] state_dbg
);

  localparam int IW  = $clog2(ID_TIMEOUT + 1);
  localparam int PW  = $clog2(PASS_TIMEOUT + 1);
  localparam int CHW = $clog2(CLOSE_HOLD + 1);
  localparam int RW  = $clog2(REJECT_HOLD + 1);

  gate_state_t    st;
  logic           cls_q;
  logic           seen_q;
  logic [IW-1:0]  id_cnt;
  logic [PW-1:0]  pass_cnt;
  logic [CHW-1:0] close_cnt;
  logic [RW-1:0]  rej_cnt;
  logic           det_hit;
  logic           leave_hit;

  gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_arrive (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (st == IDLE),
    .level (car_detect),
    .hit   (det_hit)
  );

  gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_leave (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (st == WAIT_ID),
    .level (!car_detect),
    .hit   (leave_hit)
  );

  // Sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      cls_q        <= 1'b0;
      seen_q       <= 1'b0;
      id_cnt       <= '0;
      pass_cnt     <= '0;
      close_cnt    <= '0;
      rej_cnt      <= '0;
      barrier_open <= 1'b0;
      reject_lamp  <= 1'b0;
      car_event    <= 1'b0;
      is_uni_event <= 1'b0;
      abort_pulse  <= 1'b0;
    end else begin
      car_event    <= 1'b0;
      is_uni_event <= 1'b0;
      abort_pulse  <= 1'b0;
      case (st)
        IDLE: begin
          if (det_hit) begin
            st     <= WAIT_ID;
            id_cnt <= '0;
          end
        end
        WAIT_ID: begin
          if (card_valid) begin
            cls_q <= is_uni_card;
            st    <= CHECK;
          end else if (leave_hit) begin
            st <= IDLE;
          end else if (id_cnt == IW'(ID_TIMEOUT - 1)) begin
            st          <= REJECT;
            abort_pulse <= 1'b1;
            reject_lamp <= 1'b1;
            rej_cnt     <= '0;
          end else begin
            id_cnt <= id_cnt + IW'(1);
          end
        end
        CHECK: begin
          if (EXIT_GATE || (cls_q ? uni_is_vacated_space : is_vacated_space)) begin
            st           <= OPEN;
            barrier_open <= 1'b1;
            pass_cnt     <= '0;
            seen_q       <= 1'b0;
          end else begin
            st          <= REJECT;
            reject_lamp <= 1'b1;
            rej_cnt     <= '0;
          end
        end
        OPEN: begin
          if (pass_sensor) begin
            seen_q <= 1'b1;
          end
          // A vehicle still over the loop at timeout keeps the barrier up.
          if (seen_q && !pass_sensor) begin
            car_event    <= 1'b1;
            is_uni_event <= cls_q;
            st           <= CLOSE;
            barrier_open <= 1'b0;
            close_cnt    <= '0;
          end else if (!pass_sensor && (pass_cnt >= PW'(PASS_TIMEOUT - 1))) begin
            abort_pulse  <= 1'b1;
            st           <= CLOSE;
            barrier_open <= 1'b0;
            close_cnt    <= '0;
          end
          if (pass_cnt != PW'(PASS_TIMEOUT)) begin
            pass_cnt <= pass_cnt + PW'(1);
          end
        end
        CLOSE: begin
          if (close_cnt == CHW'(CLOSE_HOLD - 1)) begin
            st <= IDLE;
          end else begin
            close_cnt <= close_cnt + CHW'(1);
          end
        end
        REJECT: begin
          if ((rej_cnt >= RW'(REJECT_HOLD - 1)) && !car_detect) begin
            st          <= IDLE;
            reject_lamp <= 1'b0;
          end
          if (rej_cnt != RW'(REJECT_HOLD)) begin
            rej_cnt <= rej_cnt + RW'(1);
          end
        end
        default: begin
          st           <= IDLE;
          barrier_open <= 1'b0;
          reject_lamp  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = st;

endmodule
